demux1ton_reg: RTL and testbench

//  Registered 1-to-N demultiplexer: steers one WIDTH-bit input word to one of 16 output channels chosen by s.

---
 rtl/demux1ton_reg_pkg.sv | 28 ++
 rtl/demux_slot.sv | 58 +++++
 rtl/demux1ton_reg.sv | 101 ++++++++++
 tb/tb_demux1ton_reg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/demux1ton_reg_pkg.sv
// ============================================================================
// Module   : demux1ton_reg_pkg
// Brief    : Shared channel constants, slot state type and select helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux1ton_reg_pkg;

  // The N-to-1 mux path uses the same channel geometry.
  localparam int DEMUX_NCH      = 16;
  localparam int DEMUX_CH_IDX_W = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic [DEMUX_NCH-1:0] ch_onehot(input logic [DEMUX_CH_IDX_W-1:0] idx);
    logic [DEMUX_NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module   : demux_slot
// Brief    : One-word holding slot with valid flag; load wins over drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot
  import demux1ton_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
      // A refill in the drain cycle keeps the slot full: no bubble.
      SLOT_FULL:  if (!i_load && i_ready) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Data is only written on load, so a drained slot keeps its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/demux1ton_reg.sv
// ============================================================================
// Module   : demux1ton_reg
// Brief    : Registered 1-to-16 demux with per-channel valid/ready slots.
//            Optional broadcast mode under macro DEMUX_BROADCAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1ton_reg
  import demux1ton_reg_pkg::*;
#(
  parameter int Sel_Width = 4,
  parameter int WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           a,
  input  logic [Sel_Width-1:0]       s,
  input  logic                       a_valid,
`ifdef DEMUX_BROADCAST_EN
  input  logic                       a_bcast,
`endif
  output logic                       a_ready,
  output logic [DEMUX_NCH*WIDTH-1:0] q_flat,
  output logic [DEMUX_NCH-1:0]       q_valid,
  input  logic [DEMUX_NCH-1:0]       q_ready,
  output logic                       err_drop
);

  logic                      w_sel_illegal;
  logic [DEMUX_CH_IDX_W-1:0] w_idx;
  logic [DEMUX_NCH-1:0]      w_slot_open;
  logic                      w_route_ready;
  logic                      w_bcast_ready;
  logic                      w_bcast;
  logic                      w_accept;
  logic [DEMUX_NCH-1:0]      w_load;
  logic                      r_err;

  // Any select bit above the channel index makes the select illegal.
  if (Sel_Width > DEMUX_CH_IDX_W) begin : g_sel_wide
    assign w_sel_illegal = |s[Sel_Width-1:DEMUX_CH_IDX_W];
    assign w_idx         = s[DEMUX_CH_IDX_W-1:0];
  end else if (Sel_Width == DEMUX_CH_IDX_W) begin : g_sel_exact
    assign w_sel_illegal = 1'b0;
    assign w_idx         = s;
  end else begin : g_sel_narrow
    assign w_sel_illegal = 1'b0;
    assign w_idx         = {{(DEMUX_CH_IDX_W-Sel_Width){1'b0}}, s};
  end

`ifdef DEMUX_BROADCAST_EN
  assign w_bcast = a_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  assign w_slot_open   = ~q_valid | q_ready;
  assign w_route_ready = w_sel_illegal | w_slot_open[w_idx];
  assign w_bcast_ready = &w_slot_open;
  assign a_ready       = w_bcast ? w_bcast_ready : w_route_ready;
  assign w_accept      = a_valid & a_ready;

  always_comb begin
    w_load = '0;
    if (w_accept) begin
      if (w_bcast) begin
        w_load = '1;
      end else if (!w_sel_illegal) begin
        w_load = ch_onehot(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_sel_illegal & ~w_bcast;
    end
  end

  assign err_drop = r_err;

  for (genvar k = 0; k < DEMUX_NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (a),
      .i_ready (q_ready[k]),
      .o_valid (q_valid[k]),
      .o_data  (q_flat[k*WIDTH +: WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_demux1ton_reg.sv
// ============================================================================
// Module   : tb_demux1ton_reg
// Brief    : Scoreboard bench for demux1ton_reg (Sel_Width=5 build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1ton_reg;

  logic         clk;
  logic         rst;
  logic [7:0]   a;
  logic [4:0]   s;
  logic         a_valid;
  logic         a_ready;
  logic [127:0] q_flat;
  logic [15:0]  q_valid;
  logic [15:0]  q_ready;
  logic         err_drop;
`ifdef DEMUX_BROADCAST_EN
  logic         a_bcast = 1'b0;
`endif

  demux1ton_reg #(
    .Sel_Width (5),
    .WIDTH     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .s        (s),
    .a_valid  (a_valid),
`ifdef DEMUX_BROADCAST_EN
    .a_bcast  (a_bcast),
`endif
    .a_ready  (a_ready),
    .q_flat   (q_flat),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .err_drop (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sbq [16][$];
  bit         errq [$];
  logic [7:0] lastval [16];
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; the model decides whether the word is taken.
  task automatic step(input logic [7:0] ta, input logic [4:0] ts, input bit tv, input logic [15:0] tqr);
    bit         illegal;
    bit         exp_rdy;
    logic [3:0] ch;
    a       = ta;
    s       = ts;
    a_valid = tv;
    q_ready = tqr;
    #1;
    illegal = (ts >= 5'd16);
    ch      = ts[3:0];
    exp_rdy = illegal || (sbq[ch].size() == 0) || tqr[ch];
    check("a_ready", {31'd0, a_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (tv && exp_rdy && !illegal) begin
      sbq[ch].push_back(ta);
      lastval[ch] = ta;
    end
    errq.push_back(tv && exp_rdy && illegal);
    #1;
  endtask

  // Monitor: mid-cycle comparison of every slot against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int k = 0; k < 16; k++) begin
          check("q_valid", {31'd0, q_valid[k]}, {31'd0, (sbq[k].size() != 0)});
          if (sbq[k].size() != 0) begin
            check("q_data", {24'd0, q_flat[k*8 +: 8]}, {24'd0, sbq[k][0]});
            if (q_ready[k]) void'(sbq[k].pop_front());
          end else begin
            check("q_hold", {24'd0, q_flat[k*8 +: 8]}, {24'd0, lastval[k]});
          end
        end
        begin
          bit e;
          e = (errq.size() != 0) ? errq.pop_front() : 1'b0;
          check("err_drop", {31'd0, err_drop}, {31'd0, e});
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 16; k++) lastval[k] = 8'h00;
    rst     = 1'b1;
    a       = 8'h77;
    s       = 5'd3;
    a_valid = 1'b1;
    q_ready = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_valid", {16'd0, q_valid}, 32'd0);
    check("rst_q_flat_or", {31'd0, |q_flat}, 32'd0);
    check("rst_err_drop", {31'd0, err_drop}, 32'd0);
    rst     = 1'b0;
    a_valid = 1'b0;
    mon_en  = 1'b1;

    // Single route then drain.
    step(8'hA5, 5'd5, 1'b1, 16'h0000);
    step(8'h00, 5'd0, 1'b0, 16'h0000);
    step(8'h00, 5'd0, 1'b0, 16'h0020);
    step(8'h00, 5'd0, 1'b0, 16'h0000);

    // Backpressure and refill in the drain cycle.
    step(8'h11, 5'd2, 1'b1, 16'h0000);
    step(8'h22, 5'd2, 1'b1, 16'h0000);
    step(8'h22, 5'd2, 1'b1, 16'h0004);
    step(8'h00, 5'd0, 1'b0, 16'h0000);
    step(8'h00, 5'd0, 1'b0, 16'hFFFF);

    // Independence across channels.
    for (int k = 0; k < 16; k++) step(8'(k), 5'(k), 1'b1, 16'h0000);
    step(8'h77, 5'd7, 1'b1, 16'h0080);
    step(8'h00, 5'd0, 1'b0, 16'h0000);
    step(8'h00, 5'd0, 1'b0, 16'hFFFF);

    // Illegal select.
    step(8'h3C, 5'd20, 1'b1, 16'h0000);
    step(8'h00, 5'd0, 1'b0, 16'h0000);
    step(8'h00, 5'd0, 1'b0, 16'h0000);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] rs;
      rs = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      step(8'($urandom), rs, ($urandom_range(0, 3) != 0), 16'($urandom & $urandom));
    end

    repeat (3) step(8'h00, 5'd0, 1'b0, 16'hFFFF);
    @(negedge clk);
    #1;
    for (int k = 0; k < 16; k++) check("final_empty", sbq[k].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
